// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the memory data port shared by mem_port_arbiter.
// Master side is the requesters plus the memory; slave side is the arbiter.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [WORD_SIZE-1:0]  req0_wdata;
  logic                  req0_ready;
  logic                  req1_valid;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [WORD_SIZE-1:0]  req1_wdata;
  logic                  req1_ready;
  logic                  resp0_valid;
  logic                  resp1_valid;
  logic [WORD_SIZE-1:0]  resp_rdata;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_wdata;
  logic [WORD_SIZE-1:0]  mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_rdata,
    output mem_write_en, mem_addr, mem_wdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_rdata,
    input  mem_write_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the CPU memory data port between the load/store
// path (requester 0) and the DMA/debug loader (requester 1), one access per two cycles.
module mem_port_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic                  rr_ptr_r;
  logic                  owner_r;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  accept_s;
  logic                  mem_write_en_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [WORD_SIZE-1:0]  mem_wdata_r;
  logic [WORD_SIZE-1:0]  resp_rdata_r;
  logic                  resp0_valid_r;
  logic                  resp1_valid_r;

  // Grant selection; rst gating keeps ready low while reset is held.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == ST_IDLE) && rst) begin
      case ({bus.req1_valid, bus.req0_valid})
        2'b01: grant0_s = 1'b1;
        2'b10: grant1_s = 1'b1;
        2'b11: begin
          grant0_s = ~rr_ptr_r;
          grant1_s = rr_ptr_r;
        end
        default: begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
        end
      endcase
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
    accept_s = grant0_s | grant1_s;
  end

  // Next-state logic: ACCESS always lasts exactly one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, fairness pointer and transaction owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= 1'b0;
      owner_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        rr_ptr_r <= ~grant1_s;
        owner_r  <= grant1_s;
      end
    end
  end

  // Memory port drive and response capture; a reset in ACCESS drops the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_write_en_r <= 1'b0;
      mem_addr_r     <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r    <= {WORD_SIZE{1'b0}};
      resp_rdata_r   <= {WORD_SIZE{1'b0}};
      resp0_valid_r  <= 1'b0;
      resp1_valid_r  <= 1'b0;
    end else begin
      resp0_valid_r <= 1'b0;
      resp1_valid_r <= 1'b0;
      if (state_r == ST_IDLE) begin
        if (accept_s) begin
          mem_addr_r     <= grant1_s ? bus.req1_addr  : bus.req0_addr;
          mem_wdata_r    <= grant1_s ? bus.req1_wdata : bus.req0_wdata;
          mem_write_en_r <= grant1_s ? bus.req1_we    : bus.req0_we;
        end
      end else begin
        if (!mem_write_en_r) begin
          resp_rdata_r <= bus.mem_rdata;
        end
        mem_write_en_r <= 1'b0;
        resp0_valid_r  <= ~owner_r;
        resp1_valid_r  <= owner_r;
      end
    end
  end

  assign bus.req0_ready   = grant0_s;
  assign bus.req1_ready   = grant1_s;
  assign bus.mem_write_en = mem_write_en_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_wdata    = mem_wdata_r;
  assign bus.resp_rdata   = resp_rdata_r;
  assign bus.resp0_valid  = resp0_valid_r;
  assign bus.resp1_valid  = resp1_valid_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.WORD_SIZE(32), .ADDR_WIDTH(8)) bus ();

  mem_port_arbiter #(.WORD_SIZE(32), .ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model behind the data port: combinational read, write on the rising edge.
  logic [31:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  // Reference model state: transaction bookkeeping by cycle number.
  logic [31:0] ref_mem [256];
  int          cyc;
  int          acc_cyc;
  int          resp_due;
  logic        resp_owner;
  logic        resp_is_wr;
  logic [31:0] resp_val;
  logic        last_winner;
  logic        last_we;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata;
  logic [31:0] exp_rdata;

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'hDEAD_BEEF;
    if (i == 5)  return 32'h0BAD_F00D;
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    acc_cyc     = -10;
    resp_due    = -10;
    last_winner = 1'b1;
    last_we     = 1'b0;
    last_addr   = 8'h00;
    last_wdata  = 32'h0;
    exp_rdata   = 32'h0;
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later, then advance the model.
  task automatic step(input logic r,
                      input logic v0, input logic we0, input logic [7:0] a0, input logic [31:0] d0,
                      input logic v1, input logic we1, input logic [7:0] a1, input logic [31:0] d1,
                      output logic acc0, output logic acc1);
    logic in_acc;
    logic e_r0;
    logic e_r1;
    @(negedge clk);
    rst = r;
    bus.req0_valid = v0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = d0;
    bus.req1_valid = v1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = d1;
    #1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!r) begin
      reset_model();
      check_val("rst_ready0", 32'(bus.req0_ready), 32'h0);
      check_val("rst_ready1", 32'(bus.req1_ready), 32'h0);
      check_val("rst_we", 32'(bus.mem_write_en), 32'h0);
      check_val("rst_addr", 32'(bus.mem_addr), 32'h0);
      check_val("rst_wdata", bus.mem_wdata, 32'h0);
      check_val("rst_rdata", bus.resp_rdata, 32'h0);
      check_val("rst_resp0", 32'(bus.resp0_valid), 32'h0);
      check_val("rst_resp1", 32'(bus.resp1_valid), 32'h0);
    end else begin
      in_acc = (cyc == acc_cyc + 1);
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!in_acc) begin
        if (v0 && v1) begin
          if (last_winner) e_r0 = 1'b1;
          else e_r1 = 1'b1;
        end else begin
          e_r0 = v0;
          e_r1 = v1;
        end
      end
      if ((cyc == resp_due) && !resp_is_wr) exp_rdata = resp_val;
      check_val("ready0", 32'(bus.req0_ready), 32'(e_r0));
      check_val("ready1", 32'(bus.req1_ready), 32'(e_r1));
      check_val("both_ready", 32'(bus.req0_ready & bus.req1_ready), 32'h0);
      check_val("mem_we", 32'(bus.mem_write_en), 32'(in_acc & last_we));
      check_val("mem_addr", 32'(bus.mem_addr), 32'(last_addr));
      check_val("mem_wdata", bus.mem_wdata, last_wdata);
      check_val("resp0", 32'(bus.resp0_valid), 32'((cyc == resp_due) && !resp_owner));
      check_val("resp1", 32'(bus.resp1_valid), 32'((cyc == resp_due) && resp_owner));
      check_val("resp_rdata", bus.resp_rdata, exp_rdata);
      if (in_acc) begin
        if (last_we) ref_mem[last_addr] = last_wdata;
        else resp_val = ref_mem[last_addr];
        resp_due   = cyc + 1;
        resp_owner = last_winner;
        resp_is_wr = last_we;
      end
      if (e_r0 || e_r1) begin
        acc_cyc     = cyc;
        last_winner = e_r1;
        last_we     = e_r1 ? we1 : we0;
        last_addr   = e_r1 ? a1 : a0;
        last_wdata  = e_r1 ? d1 : d0;
      end
      acc0 = e_r0;
      acc1 = e_r1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic x0;
    logic x1;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, x0, x1);
  endtask

  initial begin
    logic        a0;
    logic        a1;
    logic [3:0]  order;
    int          naccs;
    int          n0;
    int          n1;
    logic        p0_v, p0_we, p1_v, p1_we;
    logic [7:0]  p0_a, p1_a;
    logic [31:0] p0_d, p1_d;

    checks = 0;
    errors = 0;
    cyc = 0;
    resp_owner = 1'b0;
    resp_is_wr = 1'b0;
    resp_val = 32'h0;
    reset_model();
    for (int i = 0; i < 256; i++) begin
      mem[i] <= init_val(i);
      ref_mem[i] = init_val(i);
    end
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = 8'h00; bus.req0_wdata = 32'h0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = 8'h00; bus.req1_wdata = 32'h0;

    // Reset with both requesters asking: ready must stay low.
    step(1'b0, 1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, a0, a1);
    step(1'b0, 1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, a0, a1);

    // Single read of the preloaded word.
    step(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, a0, a1);
    check_val("single_rd_accept", 32'(a0), 32'h1);
    idle(2);
    check_val("single_rd_data", bus.resp_rdata, 32'hDEAD_BEEF);

    // Write then read back by requester 1; read is accepted alongside the write response.
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h22, 32'h1234_5678, a0, a1);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h22, 32'h0, a0, a1);
    check_val("wr_resp_holds_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
    check_val("rd_after_wr_accept", 32'(a1), 32'h1);
    idle(2);
    check_val("rd_after_wr_data", bus.resp_rdata, 32'h1234_5678);

    // Contention: both valid continuously, first four grants recorded.
    order = 4'h0; naccs = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(n0), 32'h0, 1'b1, 1'b0, 8'(8'h40 + n1), 32'h0, a0, a1);
      if (a0 || a1) begin
        if (naccs < 4) order = {order[2:0], a1};
        naccs++;
      end
      if (a0) n0++;
      if (a1) n1++;
    end
    check_val("contention_order", 32'(order), 32'h5);
    check_val("contention_count", 32'(naccs), 32'h4);
    idle(2);

    // Lone requester 1 wins every idle cycle, then the next contended grant goes to 0.
    naccs = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'(8'h20 + i / 2), 32'h0, a0, a1);
      if (a1) naccs++;
    end
    check_val("lone_accepts", 32'(naccs), 32'h3);
    step(1'b1, 1'b1, 1'b0, 8'h03, 32'h0, 1'b1, 1'b0, 8'h04, 32'h0, a0, a1);
    check_val("post_lone_grant0", 32'(a0), 32'h1);
    idle(2);

    // Abandoned request: req0 valid only during requester 1's ACCESS cycle.
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h30, 32'h0, a0, a1);
    step(1'b1, 1'b1, 1'b1, 8'h31, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 32'h0, a0, a1);
    idle(3);

    // Reset during the ACCESS cycle of a write.
    step(1'b1, 1'b1, 1'b1, 8'h05, 32'hAAAA_5555, 1'b0, 1'b0, 8'h00, 32'h0, a0, a1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, a0, a1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, a0, a1);
    idle(3);
    check_val("rst_mid_write_mem", mem[5], 32'h0BAD_F00D);
    check_val("abandon_mem", mem[8'h31], init_val(8'h31));

    // Random traffic with held requests, occasional abandonment and occasional reset.
    p0_v = 1'b0; p0_we = 1'b0; p0_a = 8'h00; p0_d = 32'h0;
    p1_v = 1'b0; p1_we = 1'b0; p1_a = 8'h00; p1_d = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!p0_v && ($urandom_range(0, 1) == 1)) begin
        p0_v = 1'b1; p0_we = 1'($urandom_range(0, 1)); p0_a = 8'($urandom_range(0, 31)); p0_d = $urandom;
      end else if (p0_v && ($urandom_range(0, 9) == 0)) begin
        p0_v = 1'b0;
      end
      if (!p1_v && ($urandom_range(0, 1) == 1)) begin
        p1_v = 1'b1; p1_we = 1'($urandom_range(0, 1)); p1_a = 8'($urandom_range(0, 31)); p1_d = $urandom;
      end else if (p1_v && ($urandom_range(0, 9) == 0)) begin
        p1_v = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) begin
        step(1'b0, p0_v, p0_we, p0_a, p0_d, p1_v, p1_we, p1_a, p1_d, a0, a1);
      end else begin
        step(1'b1, p0_v, p0_we, p0_a, p0_d, p1_v, p1_we, p1_a, p1_d, a0, a1);
      end
      if (a0) p0_v = 1'b0;
      if (a1) p1_v = 1'b0;
    end
    idle(3);

    for (int i = 0; i < 256; i++) check_val("final_mem", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single data port of the unified 256-word CPU memory between the CPU load/store path (requester 0) and a DMA/debug loader (requester 1). Accepts one transaction at a time over a valid/ready handshake with round-robin fairness. Drives the memory data port from registers and returns a one-cycle response pulse with captured read data. The instruction port of the memory is not touched by this block.

## Interface
- WORD_SIZE, 32, data word width; must match the memory word width
- ADDR_WIDTH, 8, word address width (256 words)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester k has a transaction pending
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  ADDR_WIDTH  word address
- req0_wdata / req1_wdata  in  WORD_SIZE  write data
- req0_ready / req1_ready  out  1  accept strobe, combinational; transfer when valid && ready
- resp0_valid / resp1_valid  out  1  one-cycle completion pulse (reads and writes)
- resp_rdata  out  WORD_SIZE  read data, valid with a resp pulse following a read
- mem_write_en  out  1  to memory data_write_en
- mem_addr  out  ADDR_WIDTH  to memory data_addr
- mem_wdata  out  WORD_SIZE  to memory data_val_in
- mem_rdata  in  WORD_SIZE  from memory data_val_out (combinational read)

## Operation
- States: IDLE, ACCESS. Reset state IDLE.
- Reset values: state=IDLE, rr_ptr=0, mem_write_en=0, mem_addr=0, mem_wdata=0, resp_rdata=0, resp0_valid=resp1_valid=0; ready outputs 0 while rst low.
- IDLE arbitration, combinational:
  - only one reqk_valid high: that k wins;
  - both high: requester rr_ptr wins;
  - reqk_ready = (state==IDLE) && reqk_valid && (k wins). At most one ready high; ready is never high in ACCESS.
- On accept by k (IDLE): mem_addr<=reqk_addr, mem_wdata<=reqk_wdata, mem_write_en<=reqk_we, owner<=k, rr_ptr<=~k, state<=ACCESS.
- ACCESS (exactly one cycle): memory port stable. Rising edge at end of ACCESS:
  - write commits in memory;
  - for reads, resp_rdata<=mem_rdata;
  - mem_write_en<=0, respowner_valid<=1, state<=IDLE.
- resp pulse is high for exactly the IDLE cycle after ACCESS, then cleared unless re-set.
- resp_rdata updates only on reads; it holds its previous value across writes.
- mem_addr and mem_wdata hold their last values in IDLE; only mem_write_en is guaranteed 0 there.
- rr_ptr changes only on an accept. A lone requester may win repeatedly regardless of rr_ptr.

## Timing
- Accept in cycle N (IDLE). Memory driven in cycle N+1 (ACCESS). Write lands at the edge ending N+1. resp pulse in cycle N+2.
- Response latency: 2 cycles from accept to resp pulse.
- Throughput: one transaction per 2 cycles. A new accept may occur in the same cycle as the previous resp pulse.
- Both valid continuously: grants alternate 0,1,0,1 starting from the reset rr_ptr=0. No requester waits more than one transaction.
- Requester must hold valid/we/addr/wdata stable until ready. Deasserting valid before ready is permitted; the request is dropped with no side effect.
- Read-after-write to the same address by either requester returns the new data, since the write commits before the next ACCESS.
- Reset asserted during ACCESS:
  - mem_write_en clears immediately and the write does not commit;
  - no resp is issued;
  - state returns to IDLE and rr_ptr to 0.
- Reset release: first accept is possible in the first clock edge with rst high.

## Test plan
- Single read: preload mem[0x10]=0xDEADBEEF; req0 read 0x10 -> req0_ready in cycle N, mem_addr=0x10 with mem_write_en=0 in N+1, resp0_valid in N+2 with resp_rdata=0xDEADBEEF.
- Write then read: req1 write 0x22<=0x12345678, then req1 read 0x22 -> mem_write_en high exactly one cycle; resp1_valid pulse twice; read returns 0x12345678; resp_rdata unchanged after the write response.
- Contention: both valid continuously for 4 transactions -> grant order 0,1,0,1; resp pulses 2 cycles apart per requester; no cycle with both ready high.
- Lone requester: req1 only, 3 back-to-back reads -> accepts every 2 cycles, all granted to 1; next contended grant goes to 0.
- Abandoned request: req0_valid high for one cycle while the block is in ACCESS, then low -> no accept, no resp0_valid, memory unchanged.
- Reset mid-write: accept write 0x05<=0xAAAA5555, pull rst low during ACCESS before the edge -> mem[0x05] keeps its old value; all outputs at reset values; no resp pulse after release.
